// File: rtl/shift_reg_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_n_if
//  Brief    : Control/data bundle for the shift_reg_n universal shift register.
//             The master side drives enable, mode, serial and parallel data.
//             The slave side (the register) returns its state and decodes.
//  Revision : 1.0 - initial release
// ============================================================================
interface shift_reg_n_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [1:0]       mode;
   logic             sin;
   logic [WIDTH-1:0] pin;
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic [CW-1:0]    cnt;
   logic             full;

   modport master (
      output en, mode, sin, pin,
      input  q, sout_r, sout_l, cnt, full
   );

   modport slave (
      input  en, mode, sin, pin,
      output q, sout_r, sout_l, cnt, full
   );
endinterface
`default_nettype wire

// File: rtl/shift_reg_n.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_n
//  Brief    : WIDTH-bit universal shift register with hold, shift right,
//             shift left and parallel load modes. A saturating counter
//             reports the number of shifts since the last load or reset, so
//             the block can act as a serialiser (PISO) or deserialiser (SIPO).
//             Optional build macro SHIFT_REG_ROTATE_EN turns both shift modes
//             into rotates; sin is then ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_reg_n #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  wire          clk,
   input  wire          rst,
   shift_reg_n_if.slave bus
);
   localparam int            CW          = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] c_CNT_MAX   = CW'(WIDTH);
   localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] c_CNT_ZERO  = '0;

   localparam logic [1:0] c_MODE_HOLD  = 2'b00;
   localparam logic [1:0] c_MODE_RIGHT = 2'b01;
   localparam logic [1:0] c_MODE_LEFT  = 2'b10;
   localparam logic [1:0] c_MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             w_fill_r;
   logic             w_fill_l;
   logic [CW-1:0]    w_cnt_next;

   // Bits entering the vacated end: the opposite end of q when rotating,
   // otherwise the serial input.
`ifdef SHIFT_REG_ROTATE_EN
   assign w_fill_r = r_q[0];
   assign w_fill_l = r_q[WIDTH-1];
`else
   assign w_fill_r = bus.sin;
   assign w_fill_l = bus.sin;
`endif

   // Shift counter advances in either direction and sticks at WIDTH.
   assign w_cnt_next = (r_cnt < c_CNT_MAX) ? (r_cnt + c_CNT_ONE) : c_CNT_MAX;

   // Register and counter update: reset, then enable, then mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= RESET_VAL;
         r_cnt <= c_CNT_ZERO;
      end else if (bus.en) begin
         case (bus.mode)
            c_MODE_HOLD: begin
               r_q   <= r_q;
               r_cnt <= r_cnt;
            end
            c_MODE_RIGHT: begin
               r_q   <= {w_fill_r, r_q[WIDTH-1:1]};
               r_cnt <= w_cnt_next;
            end
            c_MODE_LEFT: begin
               r_q   <= {r_q[WIDTH-2:0], w_fill_l};
               r_cnt <= w_cnt_next;
            end
            c_MODE_LOAD: begin
               r_q   <= bus.pin;
               r_cnt <= c_CNT_ZERO;
            end
            default: begin
               r_q   <= r_q;
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registered state (no input-to-output path).
   assign bus.q      = r_q;
   assign bus.cnt    = r_cnt;
   assign bus.sout_r = r_q[0];
   assign bus.sout_l = r_q[WIDTH-1];
   assign bus.full   = (r_cnt == c_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_reg_n
//  Brief    : Self-checking bench for shift_reg_n (WIDTH=8, RESET_VAL=0):
//             directed scenarios followed by random traffic, all compared
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_n;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   shift_reg_n_if #(.WIDTH(WIDTH)) bus ();

   shift_reg_n #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int   m_q   = 0;
   int   m_cnt = 0;

`ifdef SHIFT_REG_ROTATE_EN
   localparam bit c_ROT = 1'b1;
`else
   localparam bit c_ROT = 1'b0;
`endif

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".q"},      int'(bus.q),      m_q);
      chk({tag, ".cnt"},    int'(bus.cnt),    m_cnt);
      chk({tag, ".full"},   int'(bus.full),   (m_cnt == WIDTH) ? 1 : 0);
      chk({tag, ".sout_r"}, int'(bus.sout_r), m_q % 2);
      chk({tag, ".sout_l"}, int'(bus.sout_l), m_q / 128);
   endtask

   // Model: value arithmetic on an integer in 0..255
   task automatic model(input bit r, input bit e, input int m, input bit s, input int p);
      int in_bit;
      if (r) begin
         m_q = 0; m_cnt = 0;
      end else if (e) begin
         if (m == 1) begin
            in_bit = c_ROT ? (m_q % 2) : int'(s);
            m_q    = (m_q / 2) + in_bit * 128;
            m_cnt  = (m_cnt < WIDTH) ? m_cnt + 1 : WIDTH;
         end else if (m == 2) begin
            in_bit = c_ROT ? (m_q / 128) : int'(s);
            m_q    = ((m_q * 2) % 256) + in_bit;
            m_cnt  = (m_cnt < WIDTH) ? m_cnt + 1 : WIDTH;
         end else if (m == 3) begin
            m_q = p % 256; m_cnt = 0;
         end
      end
   endtask

   // One clock edge with the given inputs, then model update and full check.
   task automatic step(input string tag, input bit r, input bit e,
                       input int m, input bit s, input int p);
      rst      = r;
      bus.en   = e;
      bus.mode = 2'(m);
      bus.sin  = s;
      bus.pin  = 8'(p);
      @(posedge clk);
      model(r, e, m, s, p);
      #1;
      chk_all(tag);
   endtask

   initial begin
      logic [7:0] word;
      logic [7:0] des_bits;
      bus.en = 1'b0; bus.mode = 2'b00; bus.sin = 1'b0; bus.pin = '0;
      #2;

      // Reset wins over a load request, and holds for several edges
      step("rst0", 1, 1, 3, 0, 8'hFF);
      chk("rst_q", int'(bus.q), 0);
      for (int i = 0; i < 3; i++) step("rst_hold", 1, 1, 3, 0, 8'hFF);

      // Load then serialise LSB-first
      step("load_a5", 0, 1, 3, 0, 8'hA5);
      word = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         chk("ser_sout_r", int'(bus.sout_r), int'(word[i]));
         step("ser", 0, 1, 1, 0, 0);
      end
      chk("ser_full", int'(bus.full), 1);
`ifndef SHIFT_REG_ROTATE_EN
      chk("ser_q_end", int'(bus.q), 0);
`endif

      // Deserialise by shifting left
      step("rst1", 1, 1, 0, 0, 0);
      des_bits = 8'b0101_0011; // sin order 1,1,0,0,1,0,1,0 taken from bit 0 up
      for (int i = 0; i < 8; i++) step("des", 0, 1, 2, des_bits[i], 0);
`ifndef SHIFT_REG_ROTATE_EN
      chk("des_q", int'(bus.q), 8'hCA);
`endif
      step("des9", 0, 1, 2, 1, 0);
`ifndef SHIFT_REG_ROTATE_EN
      chk("des9_q", int'(bus.q), 8'h95);
`endif
      chk("des9_cnt", int'(bus.cnt), 8);

      // Enable low and hold mode both freeze state
      step("load_3c", 0, 1, 3, 0, 8'h3C);
      step("en0_a", 0, 0, 1, 1, 0);
      step("en0_b", 0, 0, 1, 1, 0);
      step("hold_a", 0, 1, 0, 1, 0);
      step("hold_b", 0, 1, 0, 1, 0);
      chk("hold_q", int'(bus.q), 8'h3C);

      // Reset mid-sequence discards the word
      step("load_0f", 0, 1, 3, 0, 8'h0F);
      for (int i = 0; i < 3; i++) step("mid_sh", 0, 1, 1, 0, 0);
      chk("mid_cnt", int'(bus.cnt), 3);
      step("mid_rst", 1, 1, 1, 1, 0);
      step("load_81", 0, 1, 3, 0, 8'h81);
      chk("load_81_q", int'(bus.q), 8'h81);

      // Load right after full asserts
      for (int i = 0; i < 8; i++) step("fill", 0, 1, 2, 1, 0);
      step("load_after_full", 0, 1, 3, 0, 8'h5A);
      chk("full_drop", int'(bus.full), 0);

`ifdef SHIFT_REG_ROTATE_EN
      // Rotation in both directions
      step("rot_load", 0, 1, 3, 0, 8'h81);
      step("rot_r", 0, 1, 1, 0, 0);
      chk("rot_r_q", int'(bus.q), 8'hC0);
      step("rot_l", 0, 1, 2, 0, 0);
      chk("rot_l_q", int'(bus.q), 8'h81);
      chk("rot_cnt", int'(bus.cnt), 2);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand",
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised universal shift register, the successor to the single-bit D flip-flop. It provides a WIDTH-bit register with hold, shift-right, shift-left and parallel-load modes. A saturating shift counter reports how many shifts have occurred since the last load, so the block serves as either a serialiser (PISO) or a deserialiser (SIPO). It sits between parallel datapath registers and bit-serial links.

## Interface
- WIDTH, 8, register width in bits; legal range is WIDTH ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  clock enable; when low, all state holds.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin  input  1  serial input bit for both shift directions.
- pin  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_r  output  1  right-shift serial output, equal to q[0].
- sout_l  output  1  left-shift serial output, equal to q[WIDTH-1].
- cnt  output  $clog2(WIDTH+1)  number of shifts since the last load or reset, saturating at WIDTH.
- full  output  1  asserted when cnt == WIDTH.

## Operation
- Priority on each rising clk edge: rst, then en, then mode.
- rst=1: q ← RESET_VAL and cnt ← 0, regardless of en or mode.
- en=0: q and cnt hold.
- mode 00 (hold): q and cnt hold.
- mode 01 (shift right): q ← {sin, q[WIDTH-1:1]}. cnt ← cnt+1 if cnt < WIDTH, otherwise it stays at WIDTH.
- mode 10 (shift left): q ← {q[WIDTH-2:0], sin}. cnt updates the same way as in mode 01.
- mode 11 (load): q ← pin and cnt ← 0.
- Shift direction may change between consecutive cycles; cnt counts both directions together.
- Saturation: further shifts with cnt == WIDTH still shift q, but cnt stays at WIDTH and full stays high.
- The serialiser usage is load, then WIDTH right shifts, with bits appearing LSB-first on sout_r. full marks the point where the word has been fully shifted out.
- The deserialiser usage is WIDTH shifts of sin, then read q while full=1.

## Timing
- Reset values: q = RESET_VAL, cnt = 0, full = 0, sout_r = RESET_VAL[0], sout_l = RESET_VAL[WIDTH-1].
- q and cnt are registered, with one cycle of latency from inputs sampled at an edge to the new value after that edge.
- sout_r, sout_l and full are combinational decodes of registered state, so they introduce no extra latency and have no path from any input.
- If rst is asserted mid-shift-sequence, the in-progress word is discarded and cnt restarts at 0 on the next edge.
- A load in the cycle right after full asserts takes effect normally, and full drops after that edge.

## Configuration
- SHIFT_REG_ROTATE_EN
  - Defined: shift modes rotate instead of shifting in sin. Mode 01 gives q ← {q[0], q[WIDTH-1:1]} and mode 10 gives q ← {q[WIDTH-2:0], q[WIDTH-1]). sin is ignored, and cnt and full behave exactly as in normal shift mode.
  - Not defined: sin is shifted in as described under Operation. This is the default build.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=8'h00.
- Reset: assert rst with en=1, mode=11, pin=8'hFF → after the edge, q=8'h00, cnt=0, full=0. Hold rst high for 3 edges → the outputs stay at those values.
- Load then serialise: load pin=8'hA5, then 8 edges of mode=01 with sin=0 → sout_r sequence before each edge is 1,0,1,0,0,1,0,1. The result is q=8'h00, cnt=8, full=1.
- Deserialise left: after reset, 8 edges of mode=10 with sin sequence 1,1,0,0,1,0,1,0 → q=8'hCA, full=1. A 9th shift with sin=1 → q=8'h95 and cnt stays at 8.
- Enable and hold: load 8'h3C, then alternate en=0 with mode=01 for 2 edges and en=1 with mode=00 for 2 edges → q=8'h3C and cnt=0 throughout.
- Reset mid-operation: load 8'h0F, do 3 right shifts (cnt=3), then pulse rst during a shift cycle → q=8'h00, cnt=0. A following load of 8'h81 → q=8'h81.
- Rotate build (SHIFT_REG_ROTATE_EN defined): load 8'h81, do 1 right shift with sin=0 → q=8'hC0. Then 1 left shift → q=8'h81 and cnt=2.
